// File: rtl/imm_enc.sv
// imm_enc: RV32I instruction encoder, the inverse of the immediate decode path.
// Packs opcode/register/funct/immediate fields into one instruction word behind
// a valid/ready stream with a registered output stage and a one-entry skid.
// Optional feature macro: IMM_ENC_RANGE_CHECK_EN enables immediate range
// checking and the saturating err_cnt counter. When it is undefined, err flags
// unknown opcodes only and err_cnt is tied to zero.
module imm_enc #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           opcode,
   input  logic [4:0]           rd,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic [31:0]          imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          inst,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_X
   } fmt_t;

   // Map an opcode onto its encoding format; FMT_X marks unknown opcodes.
   function automatic fmt_t fmt_of(input logic [6:0] op);
      case (op)
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b0001111, 7'b1110011:             fmt_of = FMT_I;
         7'b0110111, 7'b0010111:             fmt_of = FMT_U;
         7'b0100011:                         fmt_of = FMT_S;
         7'b1100011:                         fmt_of = FMT_B;
         7'b1101111:                         fmt_of = FMT_J;
         7'b0110011:                         fmt_of = FMT_R;
         default:                            fmt_of = FMT_X;
      endcase
   endfunction

`ifdef IMM_ENC_RANGE_CHECK_EN
   // True when the architectural immediate cannot be represented in the format.
   // Signed bounds are equivalent to "all upper bits equal" for each format.
   function automatic logic range_bad(input fmt_t f, input logic signed [31:0] v);
      case (f)
         FMT_I, FMT_S: range_bad = (v < -32'sd2048) || (v > 32'sd2047);
         FMT_B:        range_bad = (v < -32'sd4096) || (v > 32'sd4095) || v[0];
         FMT_J:        range_bad = (v < -32'sd1048576) || (v > 32'sd1048575) || v[0];
         FMT_U:        range_bad = (v[11:0] != 12'd0);
         default:      range_bad = 1'b0;
      endcase
   endfunction

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      sat_inc = (&c) ? c : c + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   endfunction
`endif

   fmt_t                 fmt_p0;
   logic [31:0]          enc_inst_p0;
   logic                 enc_err_p0;
   logic signed [31:0]   imm_s_p0;

   logic                 vld_p1;
   logic [31:0]          inst_p1;
   logic                 err_p1;

   logic                 skid_vld;
   logic [31:0]          skid_inst;
   logic                 skid_err;

   logic                 acc;
   logic                 drain;

   // ---- stage p0: combinational field packing from the live inputs ----
   assign fmt_p0   = fmt_of(opcode);
   assign imm_s_p0 = imm;

   // Pack fields per format; unknown opcodes emit the bare opcode with err set.
   always_comb begin
      enc_inst_p0 = {25'b0, opcode};
      enc_err_p0  = 1'b0;
      case (fmt_p0)
         FMT_R: enc_inst_p0 = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: enc_inst_p0 = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_U: enc_inst_p0 = {imm[31:12], rd, opcode};
         FMT_S: enc_inst_p0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: enc_inst_p0 = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
         FMT_J: enc_inst_p0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: begin
            enc_inst_p0 = {25'b0, opcode};
            enc_err_p0  = 1'b1;
         end
      endcase
`ifdef IMM_ENC_RANGE_CHECK_EN
      if (range_bad(fmt_p0, imm_s_p0)) begin
         enc_err_p0 = 1'b1;
      end
`endif
   end

   assign in_ready = ~skid_vld;
   assign acc      = in_valid & in_ready;
   assign drain    = vld_p1 & out_ready;

   // ---- stage p1: output register with one-entry skid behind it ----
   // Output register loads from the skid first (FIFO order), else from the input;
   // a stalled output diverts an accepted word into the skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         inst_p1   <= 32'd0;
         err_p1    <= 1'b0;
         skid_vld  <= 1'b0;
         skid_inst <= 32'd0;
         skid_err  <= 1'b0;
      end else if (!vld_p1 || out_ready) begin
         if (skid_vld) begin
            vld_p1   <= 1'b1;
            inst_p1  <= skid_inst;
            err_p1   <= skid_err;
            skid_vld <= 1'b0;
         end else if (acc) begin
            vld_p1  <= 1'b1;
            inst_p1 <= enc_inst_p0;
            err_p1  <= enc_err_p0;
         end else begin
            vld_p1  <= 1'b0;
         end
      end else if (acc) begin
         skid_vld  <= 1'b1;
         skid_inst <= enc_inst_p0;
         skid_err  <= enc_err_p0;
      end
   end

   assign out_valid = vld_p1;
   assign inst      = inst_p1;
   assign err       = err_p1;

`ifdef IMM_ENC_RANGE_CHECK_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Count erroneous words as they leave the block, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (drain && err_p1) begin
         err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_drain;
   assign unused_drain = drain ^ imm_s_p0[0];
   assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed self-checking bench for imm_enc.
// Expectations adapt to whether IMM_ENC_RANGE_CHECK_EN is defined.
module tb_imm_enc;

`ifdef IMM_ENC_RANGE_CHECK_EN
   localparam int RC = 1;
`else
   localparam int RC = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] inst;
   logic        err;
   logic [7:0]  err_cnt;

   logic        sat_in_ready, sat_valid, sat_err;
   logic [31:0] sat_inst;
   logic [1:0]  sat_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   imm_enc #(.ERR_CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
      .inst(inst), .err(err), .err_cnt(err_cnt)
   );

   imm_enc #(.ERR_CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7(funct7), .imm(imm), .out_valid(sat_valid), .out_ready(out_ready),
      .inst(sat_inst), .err(sat_err), .err_cnt(sat_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
      in_valid = 1'b1;
      opcode   = op;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      funct3   = f3;
      funct7   = 7'd0;
      imm      = im;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
   endtask

   task automatic test_range();
      out_ready = 1'b1;
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
      step();
      checks++; if (inst !== 32'h00208163) begin errors++; $display("FAIL range_beq_inst got %h want 00208163", inst); end
      checks++; if (err !== RC[0]) begin errors++; $display("FAIL range_beq_err got %b want %0d", err, RC); end
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
      step();
      in_valid = 1'b0;
      checks++; if (err_cnt !== 8'(RC)) begin errors++; $display("FAIL range_cnt1 got %0d want %0d", err_cnt, RC); end
      checks++; if (inst !== 32'h80000093) begin errors++; $display("FAIL range_addi_inst got %h want 80000093", inst); end
      checks++; if (err !== RC[0]) begin errors++; $display("FAIL range_addi_err got %b want %0d", err, RC); end
      step();
      exp_cnt = 2 * RC;
      checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL range_cnt2 got %0d want %0d", err_cnt, exp_cnt); end
   endtask

   task automatic test_addi();
      out_ready = 1'b1;
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
      checks++; if (inst !== 32'hFFF00093) begin errors++; $display("FAIL addi_inst got %h want FFF00093", inst); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL addi_err got %b want 0", err); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_idle got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
      step();
      checks++; if (out_valid !== 1'b1 || inst !== 32'h00208463 || err !== 1'b0) begin
         errors++; $display("FAIL b2b_beq got v=%b %h e=%b want v=1 00208463 e=0", out_valid, inst, err); end
      drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || inst !== 32'h001000EF || err !== 1'b0) begin
         errors++; $display("FAIL b2b_jal got v=%b %h e=%b want v=1 001000EF e=0", out_valid, inst, err); end
      step();
   endtask

   task automatic test_lui();
      out_ready = 1'b1;
      drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
      step();
      in_valid = 1'b0;
      checks++; if (inst !== 32'h123452B7 || err !== 1'b0) begin
         errors++; $display("FAIL lui got %h e=%b want 123452B7 e=0", inst, err); end
      step();
   endtask

   task automatic test_unknown();
      out_ready = 1'b1;
      drive(7'h7F, 5'd3, 5'd4, 5'd5, 3'd7, 32'h0);
      step();
      in_valid = 1'b0;
      checks++; if (inst !== 32'h0000007F || err !== 1'b1) begin
         errors++; $display("FAIL unknown got %h e=%b want 0000007F e=1", inst, err); end
      step();
      exp_cnt = exp_cnt + RC;
      checks++; if (err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL unknown_cnt got %0d want %0d", err_cnt, exp_cnt); end
   endtask

   task automatic test_backpressure();
      logic [31:0] w [4];
      for (int i = 0; i < 4; i++) w[i] = ((i + 1) << 20) | 32'h00000093;
      out_ready = 1'b0;
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
      step();
      checks++; if (out_valid !== 1'b1 || inst !== w[0] || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_a_load got v=%b %h rdy=%b want v=1 %h rdy=1", out_valid, inst, in_ready, w[0]); end
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
      step();
      checks++; if (inst !== w[0] || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_b_skid got %h rdy=%b want %h rdy=0", inst, in_ready, w[0]); end
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
      for (int c = 0; c < 2; c++) begin
         step();
         checks++; if (out_valid !== 1'b1 || inst !== w[0] || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d got v=%b %h rdy=%b want v=1 %h rdy=0", c, out_valid, inst, in_ready, w[0]); end
      end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || inst !== w[1] || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_out_b got v=%b %h rdy=%b want v=1 %h rdy=1", out_valid, inst, in_ready, w[1]); end
      step();
      checks++; if (out_valid !== 1'b1 || inst !== w[2]) begin
         errors++; $display("FAIL bp_out_c got v=%b %h want v=1 %h", out_valid, inst, w[2]); end
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || inst !== w[3] || err !== 1'b0) begin
         errors++; $display("FAIL bp_out_d got v=%b %h e=%b want v=1 %h e=0", out_valid, inst, err, w[3]); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1;
      drive(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
      for (int k = 0; k < 5; k++) step();
      in_valid = 1'b0;
      checks++; if (sat_valid !== 1'b1 || sat_err !== 1'b1 || sat_inst !== 32'h0) begin
         errors++; $display("FAIL sat_last got v=%b e=%b %h want v=1 e=1 0", sat_valid, sat_err, sat_inst); end
      step();
      checks++; if (sat_cnt !== 2'(3 * RC)) begin errors++; $display("FAIL sat_cnt got %0d want %0d", sat_cnt, 3 * RC); end
      checks++; if (err_cnt !== 8'(5 * RC)) begin errors++; $display("FAIL sat_wide_cnt got %0d want %0d", err_cnt, 5 * RC); end
      checks++; if (sat_valid !== 1'b0 || sat_in_ready !== 1'b1) begin
         errors++; $display("FAIL sat_idle got v=%b rdy=%b want v=0 rdy=1", sat_valid, sat_in_ready); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
      step();
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_pre got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0 || inst !== 32'd0) begin
         errors++; $display("FAIL mid_reset got v=%b rdy=%b cnt=%0d %h want v=0 rdy=1 cnt=0 0", out_valid, in_ready, err_cnt, inst); end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost%0d got %b want 0", c, out_valid); end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
      test_reset();
      test_range();
      test_addi();
      test_back_to_back();
      test_lui();
      test_unknown();
      test_backpressure();
      test_saturation();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_enc.md
Name: imm_enc

Overview:
- Instruction encoder: the inverse of the core's immediate decode path.
- Packs opcode, register, funct and 32-bit immediate fields into one RV32I instruction word.
- Checks that the immediate fits the target format (optional, see below).
- Sits between the test/program-generation front end and instruction memory or the fetch-side injector.
- Valid/ready streaming block: one registered output stage plus a one-entry skid buffer, 1-cycle latency, full throughput.

Parameters:
- ERR_CNT_W, 8, width of the saturating range-error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block can accept input this cycle.
- opcode  in  7  RV32I opcode; selects the encoding format.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used by R-type only.
- imm  in  32  immediate in architectural (sign-extended, byte-offset) form.
- out_valid  out  1  inst/err valid.
- out_ready  in  1  downstream accepts inst.
- inst  out  32  encoded instruction.
- err  out  1  immediate out of range or unknown opcode, for this word.
- err_cnt  out  ERR_CNT_W  saturating count of words emitted with err=1.

Behaviour:
- Reset values: out_valid=0, skid empty, in_ready=1, inst=0, err=0, err_cnt=0. Reset mid-transfer discards the output register and skid contents; no partial output appears.
- Format by opcode:
  - I: 1100111, 0000011, 0010011, 0001111, 1110011
  - U: 0110111, 0010111
  - S: 0100011
  - B: 1100011
  - J: 1101111
  - R: 0110011
  - Anything else is unknown: inst={25'b0,opcode}, err=1.
- Encodings, msb to lsb:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}. Shift-immediate funct7 bits are supplied by the caller in imm[11:5].
  - U: {imm[31:12],rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Range rules (err=1 on violation; inst is still emitted with truncated fields):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, never errs on range.
- Handshake:
  - Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
  - Encoding is computed combinationally from the inputs and registered, giving 1-cycle latency.
  - in_ready is a register: in_ready = ~skid_full.
  - Output register empty, or draining this cycle: accepted input loads the output register directly.
  - Output register stalled (out_valid&~out_ready): accepted input goes to the skid; in_ready falls next cycle.
  - Output drains with the skid full: skid moves to the output register; in_ready rises next cycle.
  - Order is strictly FIFO. No word is dropped or duplicated.
  - inst and err hold stable while out_valid&~out_ready.
- err_cnt:
  - Increments by 1 on each output transfer with err=1.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - Counts at output transfer, not at input acceptance.

Optional Feature:
- IMM_ENC_RANGE_CHECK_EN defined: range rules and err_cnt are implemented as above.
- Not defined:
  - Range checks are removed and fields are truncated silently.
  - err=1 only for unknown opcodes.
  - err_cnt is tied to 0 and carries no counter logic.
  - Encodings and handshake are unchanged.

Test Plan:
- ADDI: opcode=0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, out_ready=1 -> next cycle out_valid=1, inst=0xFFF00093, err=0.
- BEQ and JAL back-to-back:
  - BEQ: opcode=1100011, rs1=1, rs2=2, funct3=0, imm=8 -> inst=0x00208463.
  - Next cycle JAL: opcode=1101111, rd=1, imm=0x800 -> inst=0x001000EF.
  - Both err=0, on consecutive cycles.
- LUI: opcode=0110111, rd=5, imm=0x12345000 -> inst=0x123452B7, err=0.
- With the macro defined:
  - BEQ imm=3 -> err=1, err_cnt=1.
  - ADDI imm=0x800 -> err=1, err_cnt=2.
  - ERR_CNT_W=2 with 5 error words -> err_cnt sticks at 3.
- Backpressure: in_valid=1 streaming words A, B, C, D with out_ready=0 for 4 cycles:
  - A and B are accepted; in_ready=0 from the cycle after B is accepted.
  - On release the outputs are A, B, C, D in order, with no gaps once flowing.
- Reset: assert rst for 1 cycle while out_valid=1 and the skid is full -> next cycle out_valid=0, in_ready=1, err_cnt=0, and none of the pending words appear.
